spatz_vfu_pipe: RTL

//  Next-generation Spatz vector functional unit sequencer with a parametrised lane count and result pipeline depth.

---
 rtl/spatz_vfu_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spatz_vfu_pipe.sv
// rtl/spatz_vfu_pipe.sv - Spatz VFU sequencer: operand fetch, NrLanes IPU lanes, backpressured result pipeline
package spatz_vfu_pkg;
    typedef logic [7:0]  vreg_addr_t;
    typedef logic [4:0]  vreg_t;
    typedef logic [3:0]  id_t;
    typedef logic [15:0] vlen_t;
    typedef enum logic [1:0] {EW_8 = 2'd0, EW_16 = 2'd1, EW_32 = 2'd2, EW_64 = 2'd3} vew_e;
    typedef enum logic [1:0] {EX_VFU = 2'd0, EX_LSU = 2'd1, EX_SLD = 2'd2} ex_unit_e;
    typedef enum logic [2:0] {
        OP_VADD = 3'd0, OP_VSUB = 3'd1, OP_VAND = 3'd2, OP_VOR = 3'd3,
        OP_VXOR = 3'd4, OP_VMUL = 3'd5, OP_VMACC = 3'd6
    } op_e;
    typedef struct packed {
        vew_e vsew;
    } vtype_t;
    typedef struct packed {
        id_t         id;
        ex_unit_e    ex_unit;
        op_e         op;
        vlen_t       vl;
        vtype_t      vtype;
        vreg_t       vs1;
        vreg_t       vs2;
        vreg_t       vd;
        logic [31:0] rs1;
        logic        use_vs1;
        logic        use_vs2;
        logic        use_vd;
        logic        vd_is_src;
    } spatz_req_t;
endpackage

module spatz_ipu
    import spatz_vfu_pkg::*;
#(
    parameter int unsigned ELEN = 32
) (
    input  op_e               op_i,
    input  vew_e              sew_i,
    input  logic [ELEN-1:0]   op_s2_i,
    input  logic [ELEN-1:0]   op_s1_i,
    input  logic [ELEN-1:0]   op_d_i,
    output logic [ELEN-1:0]   result_o,
    output logic [ELEN/8-1:0] be_o
);
    localparam int NB = ELEN / 8;

    // Elements are zero-extended to 32 bits; the low SEW bits of every op are exact.
    function automatic logic [31:0] elem_op(input op_e op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
        case (op)
            OP_VADD:  elem_op = a + b;
            OP_VSUB:  elem_op = a - b;
            OP_VAND:  elem_op = a & b;
            OP_VOR:   elem_op = a | b;
            OP_VXOR:  elem_op = a ^ b;
            OP_VMUL:  elem_op = a * b;
            OP_VMACC: elem_op = c + a * b;
            default:  elem_op = '0;
        endcase
    endfunction

    always_comb begin
        result_o = '0;
        case (sew_i)
            EW_8: for (int i = 0; i < NB; i++)
                result_o[i*8 +: 8] = 8'(elem_op(op_i, 32'(op_s2_i[i*8 +: 8]),
                    32'(op_s1_i[i*8 +: 8]), 32'(op_d_i[i*8 +: 8])));
            EW_16: for (int i = 0; i < NB / 2; i++)
                result_o[i*16 +: 16] = 16'(elem_op(op_i, 32'(op_s2_i[i*16 +: 16]),
                    32'(op_s1_i[i*16 +: 16]), 32'(op_d_i[i*16 +: 16])));
            default: for (int i = 0; i < NB / 4; i++)
                result_o[i*32 +: 32] = elem_op(op_i, op_s2_i[i*32 +: 32],
                    op_s1_i[i*32 +: 32], op_d_i[i*32 +: 32]);
        endcase
    end

    assign be_o = '1;
endmodule

module spatz_vfu_pipe
    import spatz_vfu_pkg::*;
#(
    parameter int unsigned NrLanes   = 4,
    parameter int unsigned PipeDepth = 2,
    parameter int unsigned ELEN      = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  spatz_req_t                     spatz_req_i,
    input  logic                           spatz_req_valid_i,
    output logic                           spatz_req_ready_o,
    output logic                           vfu_rsp_valid_o,
    output id_t                            vfu_rsp_id_o,
    output vreg_addr_t [2:0]               vrf_raddr_o,
    output logic [2:0]                     vrf_re_o,
    input  logic [2:0][NrLanes*ELEN-1:0]   vrf_rdata_i,
    input  logic [2:0]                     vrf_rvalid_i,
    output vreg_addr_t                     vrf_waddr_o,
    output logic [NrLanes*ELEN-1:0]        vrf_wdata_o,
    output logic                           vrf_we_o,
    output logic [NrLanes*ELEN/8-1:0]      vrf_wbe_o,
    input  logic                           vrf_wvalid_i
);
    localparam int unsigned W    = NrLanes * ELEN;
    localparam int unsigned WB   = W / 8;
    localparam int unsigned HEAD = PipeDepth - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e           state_q, state_d;
    id_t              id_q, id_d;
    op_e              op_q, op_d;
    vew_e             sew_q, sew_d;
    logic [31:0]      rs1_q, rs1_d;
    logic             use_vs1_q, use_vs1_d, use_vs2_q, use_vs2_d;
    logic             use_vd_q, use_vd_d, vd_is_src_q, vd_is_src_d;
    vreg_addr_t [2:0] raddr_q, raddr_d;
    vlen_t            rem_iss_q, rem_iss_d, rem_wb_q, rem_wb_d;
    logic             rsp_valid_q, rsp_valid_d;
    id_t              rsp_id_q, rsp_id_d;

    logic             valid_q [PipeDepth];
    logic             valid_d [PipeDepth];
    logic [W-1:0]     data_q  [PipeDepth];
    logic [W-1:0]     data_d  [PipeDepth];
    vreg_addr_t       addr_q  [PipeDepth];
    vreg_addr_t       addr_d  [PipeDepth];
    logic [WB-1:0]    be_q    [PipeDepth];
    logic [WB-1:0]    be_d    [PipeDepth];
    vlen_t            cnt_q   [PipeDepth];
    vlen_t            cnt_d   [PipeDepth];

    logic [W-1:0]  opd_s2, opd_s1, opd_d, rs1_rep, ipu_res;
    logic [WB-1:0] ipu_be, tail_be;
    vlen_t         grp_size, iss_cnt;
    logic          ops_ready, advance, issue, retire;

    always_comb begin
        rs1_rep = '0;
        for (int i = 0; i < int'(WB); i++) begin
            case (sew_q)
                EW_8:    rs1_rep[i*8 +: 8] = rs1_q[7:0];
                EW_16:   rs1_rep[i*8 +: 8] = rs1_q[(i%2)*8 +: 8];
                default: rs1_rep[i*8 +: 8] = rs1_q[(i%4)*8 +: 8];
            endcase
        end
    end

    assign opd_s2 = use_vs2_q   ? vrf_rdata_i[0] : '0;
    assign opd_s1 = use_vs1_q   ? vrf_rdata_i[1] : rs1_rep;
    assign opd_d  = vd_is_src_q ? vrf_rdata_i[2] : '0;

    for (genvar l = 0; l < NrLanes; l++) begin : gen_lane
        spatz_ipu #(.ELEN(ELEN)) i_ipu (
            .op_i    (op_q),
            .sew_i   (sew_q),
            .op_s2_i (opd_s2[l*ELEN +: ELEN]),
            .op_s1_i (opd_s1[l*ELEN +: ELEN]),
            .op_d_i  (opd_d[l*ELEN +: ELEN]),
            .result_o(ipu_res[l*ELEN +: ELEN]),
            .be_o    (ipu_be[l*(ELEN/8) +: ELEN/8])
        );
    end

    assign grp_size = vlen_t'(WB >> sew_q);
    assign iss_cnt  = (rem_iss_q < grp_size) ? rem_iss_q : grp_size;

    always_comb begin
        tail_be = '0;
        for (int i = 0; i < int'(WB); i++)
            tail_be[i] = vlen_t'(i) < (iss_cnt << sew_q);
    end

    // A full head only blocks while it actually waits on a VRF write.
    assign advance   = !valid_q[HEAD] || vrf_wvalid_i || !use_vd_q;
    assign ops_ready = (!use_vs2_q || vrf_rvalid_i[0]) && (!use_vs1_q || vrf_rvalid_i[1]) &&
                       (!vd_is_src_q || vrf_rvalid_i[2]);
    assign issue     = (state_q == ISSUE) && ops_ready && advance;
    assign retire    = valid_q[HEAD] && advance;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        op_d        = op_q;
        sew_d       = sew_q;
        rs1_d       = rs1_q;
        use_vs1_d   = use_vs1_q;
        use_vs2_d   = use_vs2_q;
        use_vd_d    = use_vd_q;
        vd_is_src_d = vd_is_src_q;
        raddr_d     = raddr_q;
        rem_iss_d   = rem_iss_q;
        rem_wb_d    = rem_wb_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        valid_d     = valid_q;
        data_d      = data_q;
        addr_d      = addr_q;
        be_d        = be_q;
        cnt_d       = cnt_q;

        if (advance) begin
            for (int s = HEAD; s > 0; s--) begin
                valid_d[s] = valid_q[s-1];
                data_d[s]  = data_q[s-1];
                addr_d[s]  = addr_q[s-1];
                be_d[s]    = be_q[s-1];
                cnt_d[s]   = cnt_q[s-1];
            end
            valid_d[0] = issue;
            data_d[0]  = ipu_res;
            addr_d[0]  = raddr_q[2];
            be_d[0]    = ipu_be & tail_be;
            cnt_d[0]   = iss_cnt;
        end

        if (retire)
            rem_wb_d = rem_wb_q - cnt_q[HEAD];

        case (state_q)
            IDLE: begin
                if (spatz_req_valid_i && spatz_req_i.ex_unit == EX_VFU) begin
                    if (spatz_req_i.vl == '0) begin
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = spatz_req_i.id;
                    end else begin
                        id_d        = spatz_req_i.id;
                        op_d        = spatz_req_i.op;
                        sew_d       = (spatz_req_i.vtype.vsew == EW_64) ? EW_32 : spatz_req_i.vtype.vsew;
                        rs1_d       = spatz_req_i.rs1;
                        use_vs1_d   = spatz_req_i.use_vs1;
                        use_vs2_d   = spatz_req_i.use_vs2;
                        use_vd_d    = spatz_req_i.use_vd;
                        vd_is_src_d = spatz_req_i.vd_is_src;
                        raddr_d[0]  = {spatz_req_i.vs2, 3'b000};
                        raddr_d[1]  = {spatz_req_i.vs1, 3'b000};
                        raddr_d[2]  = {spatz_req_i.vd, 3'b000};
                        rem_iss_d   = spatz_req_i.vl;
                        rem_wb_d    = spatz_req_i.vl;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    for (int k = 0; k < 3; k++)
                        raddr_d[k] = raddr_q[k] + 1'b1;
                    rem_iss_d = rem_iss_q - iss_cnt;
                    if (rem_iss_q == iss_cnt)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (retire && rem_wb_q == cnt_q[HEAD]) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= '0;
            op_q        <= OP_VADD;
            sew_q       <= EW_8;
            rs1_q       <= '0;
            use_vs1_q   <= 1'b0;
            use_vs2_q   <= 1'b0;
            use_vd_q    <= 1'b0;
            vd_is_src_q <= 1'b0;
            raddr_q     <= '0;
            rem_iss_q   <= '0;
            rem_wb_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            for (int s = 0; s < int'(PipeDepth); s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                addr_q[s]  <= '0;
                be_q[s]    <= '0;
                cnt_q[s]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            op_q        <= op_d;
            sew_q       <= sew_d;
            rs1_q       <= rs1_d;
            use_vs1_q   <= use_vs1_d;
            use_vs2_q   <= use_vs2_d;
            use_vd_q    <= use_vd_d;
            vd_is_src_q <= vd_is_src_d;
            raddr_q     <= raddr_d;
            rem_iss_q   <= rem_iss_d;
            rem_wb_q    <= rem_wb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            cnt_q       <= cnt_d;
        end
    end

    assign spatz_req_ready_o = (state_q == IDLE);
    assign vrf_re_o          = (state_q == ISSUE) ? {vd_is_src_q, use_vs1_q, use_vs2_q} : 3'b000;
    assign vrf_raddr_o       = raddr_q;
    assign vfu_rsp_valid_o   = rsp_valid_q;
    assign vfu_rsp_id_o      = rsp_id_q;
    assign vrf_we_o          = valid_q[HEAD] && use_vd_q;
    assign vrf_waddr_o       = addr_q[HEAD];
    assign vrf_wdata_o       = data_q[HEAD];
    assign vrf_wbe_o         = be_q[HEAD];
endmodule
